// File: rtl/pipe_skid_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_reg_pkg
//  Description : Shared pipeline-register package. Holds the IF/ID payload
//                bundle (PC, Instr, PC_4) and the width constants used by the
//                generic skid-buffered pipeline stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_skid_reg_pkg;

    // IF/ID payload bundle, packed MSB-first as {pc, instr, pc_4}
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc_4;
    } if_id_t;

    localparam int c_IF_ID_W    = $bits(if_id_t);
    localparam int c_PERF_CNT_W = 32;

    // Flatten an IF/ID bundle into the stage's untyped payload vector
    function automatic logic [c_IF_ID_W-1:0] pack_if_id(input if_id_t b);
        return b;
    endfunction

endpackage : pipe_skid_reg_pkg
`default_nettype wire

// File: rtl/pipe_skid_reg_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that stops at all-ones. Synchronous active-high
//                reset clears it; used for the stage's performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: advance on inc unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_reg
//  Description : Two-entry (main + skid) valid/ready pipeline register with
//                flush. in_ready is registered so upstream never sees a
//                combinational path from out_ready. Type-agnostic payload.
//                Optional performance counters compiled in with the macro
//                PIPE_SKID_PERF_EN (stall_cnt / flush_cnt ports).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int DATA_W = c_IF_ID_W,
    parameter int CNT_W  = c_PERF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              in_ready_q,   in_ready_d;

    logic              accept;
    logic              send;

    assign accept = in_valid & in_ready_q;
    assign send   = main_valid_q & out_ready;

    // Next-state for both entries. Skid can only be valid while main is
    // valid, so an empty main never needs to look at skid contents. Vacated
    // entries are zeroed so an empty main presents a NOP bubble.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = '0;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
        end else if (!main_valid_q || send) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = accept;
                skid_data_d  = accept ? in_data : '0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end else begin
                main_valid_d = 1'b0;
                main_data_d  = '0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end

        in_ready_d = !skid_valid_d;
    end

    // Entry and ready registers; reset outranks flush and handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign occ       = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

`ifdef PIPE_SKID_PERF_EN
    // Perf counters: backpressure cycles and flush events
    generate
        if (1) begin : g_perf
            sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (main_valid_q & ~out_ready),
                .cnt_o (stall_cnt)
            );

            sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (flush),
                .cnt_o (flush_cnt)
            );
        end
    endgenerate
`else
    // Counter width only matters in the perf build; keep it referenced so
    // both builds share one parameter list.
    generate
        if (CNT_W < 1) begin : g_cnt_w_unused
        end
    endgenerate
`endif

endmodule : pipe_skid_reg
`default_nettype wire
